// File: rtl/button_event_gen.sv
// Turns a debounced push-button level into single-cycle press/release/long/repeat
// pulses, a held level and a wrapping press counter. All outputs are registered.
module button_event_gen #(
    parameter bit ACTIVE_LOW   = 1'b1,
    parameter int LONG_TICKS   = 25_000_000,
    parameter int REPEAT_TICKS = 5_000_000,
    parameter int CNT_W        = 25
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_level,
    input  logic       repeat_en,
    output logic       press_pulse,
    output logic       release_pulse,
    output logic       long_pulse,
    output logic       repeat_pulse,
    output logic       held,
    output logic [7:0] press_count
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HELD = 2'd1,
        LONG = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] LONG_TC   = CNT_W'(LONG_TICKS - 1);
    localparam logic [CNT_W-1:0] REPEAT_TC = CNT_W'(REPEAT_TICKS - 1);

    logic             pressed;
    logic             prev_q;
    state_t           state;
    state_t           state_n;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_n;
    logic             press_n;
    logic             release_n;
    logic             long_n;
    logic             repeat_n;
    logic [7:0]       count_n;

    assign pressed = ACTIVE_LOW ? ~btn_level : btn_level;

    always_comb begin
        state_n   = state;
        cnt_n     = cnt;
        press_n   = 1'b0;
        release_n = 1'b0;
        long_n    = 1'b0;
        repeat_n  = 1'b0;
        count_n   = press_count;
        case (state)
            IDLE: begin
                cnt_n = '0;
                if (pressed && !prev_q) begin
                    state_n = HELD;
                    press_n = 1'b1;
                    count_n = press_count + 8'd1;
                end
            end
            // Release is tested first so it wins over a terminal count.
            HELD: begin
                if (!pressed) begin
                    state_n   = IDLE;
                    release_n = 1'b1;
                    cnt_n     = '0;
                end else if (cnt == LONG_TC) begin
                    state_n = LONG;
                    long_n  = 1'b1;
                    cnt_n   = '0;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            LONG: begin
                if (!pressed) begin
                    state_n   = IDLE;
                    release_n = 1'b1;
                    cnt_n     = '0;
                end else if (!repeat_en) begin
                    cnt_n = '0;
                end else if (cnt == REPEAT_TC) begin
                    repeat_n = 1'b1;
                    cnt_n    = '0;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            default: begin
                state_n = IDLE;
                cnt_n   = '0;
            end
        endcase
    end

    // prev_q resets high so a button held through reset needs a fresh press.
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            cnt           <= '0;
            prev_q        <= 1'b1;
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
            long_pulse    <= 1'b0;
            repeat_pulse  <= 1'b0;
            held          <= 1'b0;
            press_count   <= 8'd0;
        end else begin
            state         <= state_n;
            cnt           <= cnt_n;
            prev_q        <= pressed;
            press_pulse   <= press_n;
            release_pulse <= release_n;
            long_pulse    <= long_n;
            repeat_pulse  <= repeat_n;
            held          <= (state_n != IDLE);
            press_count   <= count_n;
        end
    end

endmodule
